// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin arbiter that shares one 8-bit register-bus slave
// among NUM_REQ requesters. Each grant drives a single-cycle bus access. Reads
// then wait RD_LAT cycles for the slave's data. The winner gets a one-cycle ack.
// Optional build macro: ARB_PRIO0_EN. When it is defined, requester 0 has fixed
// top priority and the other requesters are served round-robin among
// themselves.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | bus idle, arbitrate among pending requests
// S_ISSUE | single-cycle bus access for the latched winner
// S_WAIT  | read only: count down the slave read latency, capture data
// S_ACK   | one-cycle ack to the winner, advance the round-robin pointer
module bus_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int RD_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ-1:0]   req_wr_i,
  input  logic [NUM_REQ*8-1:0] req_addr_i,
  input  logic [NUM_REQ*8-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]   ack_o,
  output logic [7:0]           ack_rdata_o,
  output logic                 bus_en_o,
  output logic                 bus_wr_o,
  output logic [7:0]           bus_addr_o,
  output logic [7:0]           bus_wdata_o,
  input  logic [7:0]           bus_rdata_i,
  output logic                 busy_o
);

  localparam int              IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [3:0]       LAT_LOAD = 4'(RD_LAT);

`ifdef ARB_PRIO0_EN
  // Requester 0 is handled outside the rotation, so remove it from the search.
  localparam logic [NUM_REQ-1:0] RR_MASK = ~NUM_REQ'(1);
`else
  localparam logic [NUM_REQ-1:0] RR_MASK = '1;
`endif

  generate
    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
      $error("bus_rr_arbiter: RD_LAT must be within 1..15");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("bus_rr_arbiter: NUM_REQ must be within 2..8");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  win_q, win_d;
  logic              wr_q, wr_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        rdata_q, rdata_d;

  logic [NUM_REQ-1:0] rr_req;
  logic [IDX_W-1:0]   pick;
  logic               any_req;

  // Winner search: first pending requester after the last grant, with wrap-around.
  always_comb begin
    rr_req  = req_i & RR_MASK;
    pick    = ptr_q;
    any_req = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!any_req && rr_req[(int'(ptr_q) + k) % NUM_REQ]) begin
        pick    = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
        any_req = 1'b1;
      end
    end
`ifdef ARB_PRIO0_EN
    if (req_i[0]) begin
      pick    = '0;
      any_req = 1'b1;
    end
`endif
  end

  // Next-state logic and decoded outputs. All outputs depend only on registered state.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    ack_o       = '0;
    ack_rdata_o = 8'h00;
    bus_en_o    = 1'b0;
    bus_wr_o    = 1'b0;
    bus_addr_o  = 8'h00;
    bus_wdata_o = 8'h00;
    busy_o      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          win_d   = pick;
          wr_d    = req_wr_i[pick];
          addr_d  = req_addr_i[int'(pick)*8 +: 8];
          wdata_d = req_wdata_i[int'(pick)*8 +: 8];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus_en_o    = 1'b1;
        bus_wr_o    = wr_q;
        bus_addr_o  = addr_q;
        bus_wdata_o = wdata_q;
        if (wr_q) begin
          state_d = S_ACK;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // The counter is loaded with RD_LAT, so it reaches 1 in cycle ISSUE+RD_LAT.
        // That is the cycle in which the slave presents its data.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rdata_d = bus_rdata_i;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        ack_o[win_q] = 1'b1;
        ack_rdata_o  = wr_q ? 8'h00 : rdata_q;
`ifdef ARB_PRIO0_EN
        if (win_q != '0) begin
          ptr_d = win_q;
        end
`else
        ptr_d = win_q;
`endif
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. A synchronous reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      ptr_q   <= LAST_IDX;
      win_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      cnt_q   <= 4'd0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
